// File: rtl/imem_server_pkg.sv
// Shared constants and the state type for the instruction-memory server.
package imem_server_pkg;

    localparam logic [31:0] NOP_WORD = 32'hC800_0000;
    localparam int          OPCODE_W = 7;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/imem_byte_loader.sv
// Serial byte loader: packs big-endian bytes into words and drives the RAM write port.
module imem_byte_loader
    import imem_server_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          active,
    input  logic          load_en,
    input  logic [7:0]    load_byte,
    input  logic          load_last,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic [AW:0]   load_words,
    output logic          load_overflow
);

    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic [31:0] asm_reg, asm_next, merged;
    logic [AW:0] words_reg, words_next;
    logic        ovf_reg, ovf_next;
    logic        full;

    assign full = (words_reg == (AW+1)'(DEPTH_WORDS));

    // Slot the incoming byte into its lane; lower lanes stay zero, which
    // gives the zero padding of a partial final word for free.
    always_comb begin
        merged = asm_reg;
        case (byte_cnt_reg)
            2'd0:    merged = {load_byte, 24'h000000};
            2'd1:    merged = {asm_reg[31:24], load_byte, 16'h0000};
            2'd2:    merged = {asm_reg[31:16], load_byte, 8'h00};
            default: merged = {asm_reg[31:8], load_byte};
        endcase
    end

    always_comb begin
        byte_cnt_next = byte_cnt_reg;
        asm_next      = asm_reg;
        words_next    = words_reg;
        ovf_next      = ovf_reg;
        wr_en         = 1'b0;
        wr_addr       = words_reg[AW-1:0];
        wr_data       = merged;
        if (active && load_en && !reset) begin
            if (full) begin
                ovf_next = 1'b1;
            end else if (byte_cnt_reg == 2'd3 || load_last) begin
                wr_en         = 1'b1;
                words_next    = words_reg + 1'b1;
                byte_cnt_next = 2'd0;
                asm_next      = 32'h0;
            end else begin
                byte_cnt_next = byte_cnt_reg + 2'd1;
                asm_next      = merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_reg <= 2'd0;
            asm_reg      <= 32'h0;
            words_reg    <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            byte_cnt_reg <= byte_cnt_next;
            asm_reg      <= asm_next;
            words_reg    <= words_next;
            ovf_reg      <= ovf_next;
        end
    end

    assign load_words    = words_reg;
    assign load_overflow = ovf_reg;

endmodule

// File: rtl/imem_server.sv
// Instruction memory: loaded serially after reset, then answers fetches one cycle later.
module imem_server #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] NOP_WORD    = imem_server_pkg::NOP_WORD
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fetch_req,
    input  logic [31:0]                  pc_addr,
    input  logic                         flush,
    output logic                         fetch_ready,
    output logic                         instr_valid,
    output logic [31:0]                  instruction_out,
    output logic                         fetch_fault,
    input  logic                         load_en,
    input  logic [7:0]                   load_byte,
    input  logic                         load_last,
    output logic                         load_done,
    output logic                         load_overflow,
    output logic [$clog2(DEPTH_WORDS):0] load_words
);
    import imem_server_pkg::*;

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t        state_reg, state_next;
    logic [31:0]   ram [DEPTH_WORDS];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [31:0]   rd_data_reg;
    logic          pend_reg;
    logic          fault_reg;
    logic [31:0]   hold_reg;
    logic          accept;
    logic          fault_now;
    logic [31:0]   resp_word;

    imem_byte_loader #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_loader (
        .clk           (clk),
        .reset         (reset),
        .active        (state_reg == LOAD),
        .load_en       (load_en),
        .load_byte     (load_byte),
        .load_last     (load_last),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .load_words    (load_words),
        .load_overflow (load_overflow)
    );

    always_comb begin
        state_next = state_reg;
        if (state_reg == LOAD && load_en && load_last) begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    assign fetch_ready = (state_reg == RUN);
    assign load_done   = (state_reg == RUN);
    assign accept      = fetch_req && fetch_ready;
    // Any set bit above the word index means the address is past the RAM.
    assign fault_now   = (pc_addr[1:0] != 2'b00) || (pc_addr[31:AW+2] != '0);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rd_data_reg <= ram[pc_addr[AW+1:2]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_reg  <= 1'b0;
            fault_reg <= 1'b0;
            hold_reg  <= NOP_WORD;
        end else begin
            pend_reg <= accept;
            if (accept) begin
                fault_reg <= fault_now;
            end
            if (instr_valid) begin
                hold_reg <= resp_word;
            end
        end
    end

    // Flush only hides the response; a suppressed word never reaches hold_reg.
    assign resp_word       = fault_reg ? NOP_WORD : rd_data_reg;
    assign instr_valid     = pend_reg && !flush;
    assign instruction_out = instr_valid ? resp_word : hold_reg;
    assign fetch_fault     = instr_valid && fault_reg;

endmodule

// File: tb/tb_imem_server.sv
// Scoreboard bench for imem_server: full-size instance plus a 4-word instance for overflow.
module tb_imem_server;

    localparam logic [31:0] NOP = 32'hC800_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        f0_req, f0_flush, l0_en, l0_last;
    logic [31:0] f0_pc;
    logic [7:0]  l0_byte;
    logic        ready0, v0, fault0, done0, ovf0;
    logic [31:0] out0;
    logic [10:0] words0;

    logic        f1_req, f1_flush, l1_en, l1_last;
    logic [31:0] f1_pc;
    logic [7:0]  l1_byte;
    logic        ready1, v1, fault1, done1, ovf1;
    logic [31:0] out1;
    logic [2:0]  words1;

    imem_server #(.DEPTH_WORDS(1024)) u_dut (
        .clk(clk), .reset(reset), .fetch_req(f0_req), .pc_addr(f0_pc), .flush(f0_flush),
        .fetch_ready(ready0), .instr_valid(v0), .instruction_out(out0), .fetch_fault(fault0),
        .load_en(l0_en), .load_byte(l0_byte), .load_last(l0_last),
        .load_done(done0), .load_overflow(ovf0), .load_words(words0)
    );

    imem_server #(.DEPTH_WORDS(4)) u_small (
        .clk(clk), .reset(reset), .fetch_req(f1_req), .pc_addr(f1_pc), .flush(f1_flush),
        .fetch_ready(ready1), .instr_valid(v1), .instruction_out(out1), .fetch_fault(fault1),
        .load_en(l1_en), .load_byte(l1_byte), .load_last(l1_last),
        .load_done(done1), .load_overflow(ovf1), .load_words(words1)
    );

    typedef struct {
        logic [31:0] instr;
        logic        fault;
    } resp_t;

    typedef struct {
        int          dut;
        logic [10:0] words;
        logic        ovf;
        logic        done;
        logic        ready;
        logic        valid;
        logic [31:0] out;
        string       name;
    } stat_t;

    resp_t q0[$];
    resp_t q1[$];
    stat_t sq[$];
    int    errors = 0;
    int    checks = 0;
    bit    stim_done = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_resp(input int d, input logic [31:0] w, input logic f);
        resp_t r;
        r.instr = w;
        r.fault = f;
        if (d == 0) q0.push_back(r);
        else        q1.push_back(r);
    endtask

    task automatic push_stat(input int d, input logic [10:0] w, input logic o, input logic dn,
                             input logic rd, input logic vl, input logic [31:0] ot, input string nm);
        stat_t s;
        s.dut = d; s.words = w; s.ovf = o; s.done = dn;
        s.ready = rd; s.valid = vl; s.out = ot; s.name = nm;
        sq.push_back(s);
    endtask

    // Monitor: pops expected responses whenever a DUT presents instr_valid.
    always @(negedge clk) begin
        resp_t       e;
        stat_t       s;
        logic [46:0] act;
        logic [46:0] req;
        if (v0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid0 actual instr=%h fault=%b required no response", out0, fault0);
            end else begin
                e = q0.pop_front();
                if (out0 !== e.instr || fault0 !== e.fault) begin
                    errors++;
                    $display("FAIL resp0 actual instr=%h fault=%b required instr=%h fault=%b",
                             out0, fault0, e.instr, e.fault);
                end else begin
                    $display("ok resp0 instr=%h fault=%b", out0, fault0);
                end
            end
        end
        if (v1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid1 actual instr=%h fault=%b required no response", out1, fault1);
            end else begin
                e = q1.pop_front();
                if (out1 !== e.instr || fault1 !== e.fault) begin
                    errors++;
                    $display("FAIL resp1 actual instr=%h fault=%b required instr=%h fault=%b",
                             out1, fault1, e.instr, e.fault);
                end else begin
                    $display("ok resp1 instr=%h fault=%b", out1, fault1);
                end
            end
        end
        while (sq.size() > 0) begin
            s = sq.pop_front();
            if (s.dut == 0) act = {words0, ovf0, done0, ready0, v0, out0};
            else            act = {8'h00, words1, ovf1, done1, ready1, v1, out1};
            req = {s.words, s.ovf, s.done, s.ready, s.valid, s.out};
            checks++;
            if (act !== req) begin
                errors++;
                $display("FAIL %s actual words=%0d ovf=%b done=%b ready=%b valid=%b out=%h required words=%0d ovf=%b done=%b ready=%b valid=%b out=%h",
                         s.name, act[46:36], act[35], act[34], act[33], act[32], act[31:0],
                         s.words, s.ovf, s.done, s.ready, s.valid, s.out);
            end else begin
                $display("ok %s words=%0d ovf=%b done=%b", s.name, s.words, s.ovf, s.done);
            end
        end
        if (stim_done) begin
            checks++;
            if (q0.size() + q1.size() != 0) begin
                errors++;
                $display("FAIL missing_responses actual pending=%0d required 0", q0.size() + q1.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required summary before 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prog [6];
        logic [7:0] dead [4];
        prog = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 8'hCD};
        dead = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        reset = 1'b1;
        f0_req = 0; f0_flush = 0; f0_pc = 0; l0_en = 0; l0_byte = 0; l0_last = 0;
        f1_req = 0; f1_flush = 0; f1_pc = 0; l1_en = 0; l1_byte = 0; l1_last = 0;
        tick();
        push_stat(0, 0, 0, 0, 0, 0, NOP, "reset0");
        push_stat(1, 0, 0, 0, 0, 0, NOP, "reset1");
        tick();
        reset = 1'b0;

        // Small instance: 20 bytes into 4 words, last four bytes overflow.
        for (int k = 1; k <= 20; k++) begin
            l1_en = 1; l1_byte = 8'(k); l1_last = (k == 20);
            tick();
        end
        l1_en = 0; l1_last = 0;
        push_stat(1, 4, 1, 1, 1, 0, NOP, "overflow1");
        f1_req = 1; f1_pc = 32'd12; push_resp(1, 32'h0D0E0F10, 0);
        tick();
        f1_pc = 32'd0; push_resp(1, 32'h01020304, 0);
        tick();
        f1_pc = 32'd16; push_resp(1, NOP, 1);
        tick();
        f1_req = 0;
        tick();

        // Main instance: program load with partial final word.
        for (int i = 0; i < 6; i++) begin
            l0_en = 1; l0_byte = prog[i]; l0_last = (i == 5);
            if (i == 5) push_stat(0, 1, 0, 0, 0, 0, NOP, "before_last0");
            tick();
        end
        l0_en = 0; l0_last = 0;
        push_stat(0, 2, 0, 1, 1, 0, NOP, "loaded0");
        tick();

        // Back-to-back fetches; load bytes offered in RUN must be ignored.
        l0_en = 1; l0_byte = 8'hFF;
        f0_req = 1; f0_pc = 32'd0; push_resp(0, 32'h12345678, 0);
        tick();
        f0_pc = 32'd4; push_resp(0, 32'hABCD0000, 0);
        tick();
        l0_en = 0;
        f0_pc = 32'd6; push_resp(0, NOP, 1);
        tick();
        f0_pc = 32'd4096; push_resp(0, NOP, 1);
        tick();
        f0_req = 0;
        tick();

        // Flush drops the pc=0 response but accepts the redirected fetch.
        f0_req = 1; f0_pc = 32'd0;
        tick();
        f0_flush = 1; f0_pc = 32'd4; push_resp(0, 32'hABCD0000, 0);
        tick();
        f0_flush = 0; f0_req = 0;
        tick();
        push_stat(0, 2, 0, 1, 1, 0, 32'hABCD0000, "hold_after_flush0");
        tick();

        // Reset in RUN kills the in-flight response.
        f0_req = 1; f0_pc = 32'd0; reset = 1;
        tick();
        f0_req = 0; reset = 0;
        push_stat(0, 0, 0, 0, 0, 0, NOP, "reset_in_run0");
        tick();

        // Reset mid-load abandons the partial word; fetches in LOAD are ignored.
        l0_en = 1; l0_byte = 8'h11;
        tick();
        l0_byte = 8'h22;
        tick();
        l0_en = 0; reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            l0_en = 1; l0_byte = dead[i]; l0_last = (i == 3);
            f0_req = 1; f0_pc = 32'd0;
            tick();
        end
        l0_en = 0; l0_last = 0; f0_req = 0;
        push_stat(0, 1, 0, 1, 1, 0, NOP, "reload0");
        tick();
        f0_req = 1; f0_pc = 32'd0; push_resp(0, 32'hDEADBEEF, 0);
        tick();
        f0_req = 0;
        tick();
        tick();
        stim_done = 1'b1;
    end

endmodule
